// File: rtl/sync_fifo_window.sv
// Single-clock FIFO with a parallel window of all stored entries, oldest first.
// Supports normal (reject-on-full) and ring (drop-oldest) modes, sticky error flags and flush.

// One window slot: picks the k-th entry from head and masks it to 0 when not occupied.
module sync_fifo_window_lane #(
  parameter int N  = 32,
  parameter int M  = 16,
  parameter int K  = 0,
  parameter int PW = 4,
  parameter int LW = 5
) (
  input  logic [N-1:0]  mem_i [M],
  input  logic [PW-1:0] head_i,
  input  logic [LW-1:0] level_i,
  output logic [N-1:0]  win_o,
  output logic          vld_o
);
  localparam int SW = PW + 1;

  logic [SW-1:0] sum;
  logic [PW-1:0] idx;

  always_comb begin
    sum   = {1'b0, head_i} + SW'(K);
    // head+K never exceeds 2*(M-1), so a single conditional subtract wraps it
    idx   = (sum >= SW'(M)) ? PW'(sum - SW'(M)) : PW'(sum);
    vld_o = 32'(level_i) > K;
    win_o = vld_o ? mem_i[idx] : '0;
  end
endmodule

module sync_fifo_window #(
  parameter  int N  = 32,
  parameter  int M  = 16,
  parameter  int AF = M - 2,
  parameter  int AE = 2,
  localparam int LW = $clog2(M + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          mode_i,
  input  logic          wr_i,
  input  logic [N-1:0]  wr_data_i,
  input  logic          rd_i,
  output logic [N-1:0]  rd_data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          afull_o,
  output logic          aempty_o,
  output logic [LW-1:0] level_o,
  output logic          ovf_o,
  output logic          udf_o,
  output logic          drop_o,
  output logic [N-1:0]  win_o [0:M-1],
  output logic [M-1:0]  win_vld_o
);
  localparam int PW = $clog2(M);

  logic [N-1:0]  mem_q [M];
  logic [N-1:0]  mem_d [M];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d, udf_q, udf_d, drop_q, drop_d;
  logic          is_empty, is_full, do_wr, do_rd, do_drop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(M - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    is_empty = (level_q == '0);
    is_full  = (level_q == LW'(M));
    do_rd    = rd_i && !is_empty;
    // ring mode frees the head slot itself when a lone write hits a full FIFO
    do_drop  = wr_i && !rd_i && is_full && mode_i;
    do_wr    = wr_i && (!is_full || rd_i || mode_i);

    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    drop_d  = 1'b0;

    if (clr_i) begin
      head_d  = '0;
      tail_d  = '0;
      level_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      if (do_wr) begin
        mem_d[tail_q] = wr_data_i;
        tail_d        = inc(tail_q);
      end
      if (do_rd || do_drop) head_d = inc(head_q);
      level_d = level_q + LW'(do_wr) - LW'(do_rd || do_drop);
      ovf_d   = ovf_q | (wr_i && !rd_i && is_full && !mode_i);
      udf_d   = udf_q | (rd_i && is_empty);
      drop_d  = do_drop;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      drop_q  <= drop_d;
    end
  end

  // Storage needs no reset: unoccupied slots are masked in every lane.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  for (genvar k = 0; k < M; k++) begin : g_lane
    sync_fifo_window_lane #(.N(N), .M(M), .K(k), .PW(PW), .LW(LW)) u_lane (
      .mem_i   (mem_q),
      .head_i  (head_q),
      .level_i (level_q),
      .win_o   (win_o[k]),
      .vld_o   (win_vld_o[k])
    );
  end

  assign rd_data_o = win_o[0];
  assign full_o    = is_full;
  assign empty_o   = is_empty;
  assign afull_o   = 32'(level_q) >= AF;
  assign aempty_o  = 32'(level_q) <= AE;
  assign level_o   = level_q;
  assign ovf_o     = ovf_q;
  assign udf_o     = udf_q;
  assign drop_o    = drop_q;
endmodule

// File: tb/tb_sync_fifo_window.sv
// Bench for sync_fifo_window (N=8, M=5, AF=3, AE=2): vector table plus corner sequences,
// with a queue model acting as scoreboard for data, window and flags.
module tb_sync_fifo_window;
  localparam int N = 8, M = 5, AF = 3, AE = 2, LW = 3;

  logic          clk = 1'b0;
  logic          rst_i, clr_i, mode_i, wr_i, rd_i;
  logic [N-1:0]  wr_data_i, rd_data_o;
  logic          full_o, empty_o, afull_o, aempty_o, ovf_o, udf_o, drop_o;
  logic [LW-1:0] level_o;
  logic [N-1:0]  win [0:M-1];
  logic [M-1:0]  win_vld_o;

  sync_fifo_window #(.N(N), .M(M), .AF(AF), .AE(AE)) dut (
    .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i), .mode_i(mode_i),
    .wr_i(wr_i), .wr_data_i(wr_data_i), .rd_i(rd_i), .rd_data_o(rd_data_o),
    .full_o(full_o), .empty_o(empty_o), .afull_o(afull_o), .aempty_o(aempty_o),
    .level_o(level_o), .ovf_o(ovf_o), .udf_o(udf_o), .drop_o(drop_o),
    .win_o(win), .win_vld_o(win_vld_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, max_lvl = 0;
  logic [N-1:0] mdl [$];
  bit m_ovf, m_udf, m_drop;

  function automatic void chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endfunction

  function automatic void check_all();
    int sz = mdl.size();
    chk("level", int'(level_o), sz);
    chk("full", int'(full_o), int'(sz == M));
    chk("empty", int'(empty_o), int'(sz == 0));
    chk("afull", int'(afull_o), int'(sz >= AF));
    chk("aempty", int'(aempty_o), int'(sz <= AE));
    chk("ovf", int'(ovf_o), int'(m_ovf));
    chk("udf", int'(udf_o), int'(m_udf));
    chk("drop", int'(drop_o), int'(m_drop));
    chk("rd_data", int'(rd_data_o), sz > 0 ? int'(mdl[0]) : 0);
    for (int k = 0; k < M; k++) begin
      chk($sformatf("win[%0d]", k), int'(win[k]), k < sz ? int'(mdl[k]) : 0);
      chk($sformatf("win_vld[%0d]", k), int'(win_vld_o[k]), int'(k < sz));
    end
    if (int'(level_o) > max_lvl) max_lvl = int'(level_o);
  endfunction

  // Drive one cycle (called just after a falling edge), update model, check after the edge.
  task automatic cyc(bit rst_n, bit clr, bit mode, bit wr, logic [N-1:0] d, bit rd);
    int sz = mdl.size();
    rst_i = rst_n; clr_i = clr; mode_i = mode; wr_i = wr; wr_data_i = d; rd_i = rd;
    if (!rst_n || clr) begin
      mdl.delete(); m_ovf = 0; m_udf = 0; m_drop = 0;
    end else begin
      m_drop = 0;
      if (rd && sz > 0) chk("pop_data", int'(rd_data_o), int'(mdl[0]));
      if (sz == 0) begin
        if (rd) m_udf = 1;
        if (wr) mdl.push_back(d);
      end else if (sz < M) begin
        if (rd) void'(mdl.pop_front());
        if (wr) mdl.push_back(d);
      end else if (wr && rd) begin
        void'(mdl.pop_front()); mdl.push_back(d);
      end else if (wr) begin
        if (mode) begin void'(mdl.pop_front()); mdl.push_back(d); m_drop = 1; end
        else m_ovf = 1;
      end else if (rd) void'(mdl.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  typedef struct {
    bit rst_n, clr, mode, wr; logic [N-1:0] d; bit rd;
    int lvl; logic [6:0] flg; logic [N-1:0] rdat;  // flg = {full,empty,afull,aempty,ovf,udf,drop}
  } vec_t;
  vec_t tbl [12];

  initial begin
    rst_i = 0; clr_i = 0; mode_i = 0; wr_i = 0; rd_i = 0; wr_data_i = '0;
    tbl[0]  = '{0, 0, 0, 0, 8'd0, 0, 0, 7'b0101000, 8'd0};
    tbl[1]  = '{1, 0, 0, 1, 8'd1, 0, 1, 7'b0001000, 8'd1};
    tbl[2]  = '{1, 0, 0, 1, 8'd2, 0, 2, 7'b0001000, 8'd1};
    tbl[3]  = '{1, 0, 0, 1, 8'd3, 0, 3, 7'b0010000, 8'd1};
    tbl[4]  = '{1, 0, 0, 1, 8'd4, 0, 4, 7'b0010000, 8'd1};
    tbl[5]  = '{1, 0, 0, 1, 8'd5, 0, 5, 7'b1010000, 8'd1};
    tbl[6]  = '{1, 0, 0, 1, 8'd6, 0, 5, 7'b1010100, 8'd1};
    tbl[7]  = '{1, 0, 0, 0, 8'd0, 1, 4, 7'b0010100, 8'd2};
    tbl[8]  = '{1, 0, 0, 0, 8'd0, 1, 3, 7'b0010100, 8'd3};
    tbl[9]  = '{1, 0, 0, 0, 8'd0, 1, 2, 7'b0001100, 8'd4};
    tbl[10] = '{1, 0, 0, 0, 8'd0, 1, 1, 7'b0001100, 8'd5};
    tbl[11] = '{1, 0, 0, 0, 8'd0, 1, 0, 7'b0101100, 8'd0};
    @(negedge clk);

    // fill, reject on full, drain
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].rst_n, tbl[i].clr, tbl[i].mode, tbl[i].wr, tbl[i].d, tbl[i].rd);
      chk($sformatf("tbl%0d_level", i), int'(level_o), tbl[i].lvl);
      chk($sformatf("tbl%0d_flags", i),
          int'({full_o, empty_o, afull_o, aempty_o, ovf_o, udf_o, drop_o}), int'(tbl[i].flg));
      chk($sformatf("tbl%0d_rd", i), int'(rd_data_o), int'(tbl[i].rdat));
    end

    // ring mode: drop oldest twice, then mode switches at full with W&R
    cyc(0, 0, 0, 0, 0, 0);
    for (int v = 1; v <= 5; v++) cyc(1, 0, 1, 1, N'(v), 0);
    cyc(1, 0, 1, 1, 8'd6, 0);
    chk("ring_drop1", int'(drop_o), 1);
    cyc(1, 0, 1, 1, 8'd7, 0);
    chk("ring_drop2", int'(drop_o), 1);
    chk("ring_win0", int'(win[0]), 3);
    chk("ring_win4", int'(win[4]), 7);
    cyc(1, 0, 1, 0, 8'd0, 0);
    chk("ring_drop_end", int'(drop_o), 0);
    cyc(1, 0, 0, 1, 8'd8, 1);
    cyc(1, 0, 1, 1, 8'd9, 1);
    chk("ring_wr_rd_nodrop", int'(drop_o), 0);
    chk("ring_ovf", int'(ovf_o), 0);

    // pointer wrap with W&R at level 2
    cyc(0, 0, 0, 0, 0, 0);
    max_lvl = 0;
    for (int r = 0; r < 4; r++) begin
      cyc(1, 0, 0, 1, N'(10 * r + 1), 0);
      cyc(1, 0, 0, 1, N'(10 * r + 2), 0);
      cyc(1, 0, 0, 1, N'(10 * r + 3), 1);
      cyc(1, 0, 0, 0, 8'd0, 1);
      cyc(1, 0, 0, 0, 8'd0, 1);
    end
    chk("wrap_max_le3", int'(max_lvl <= 3), 1);
    chk("wrap_flags", int'({ovf_o, udf_o, drop_o}), 0);

    // W&R on empty
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 8'hA5, 1);
    chk("ewr_udf", int'(udf_o), 1);
    chk("ewr_level", int'(level_o), 1);
    chk("ewr_rd", int'(rd_data_o), 8'hA5);

    // flush (then reset) with a concurrent write at level 3 and ovf set
    for (int p = 0; p < 2; p++) begin
      cyc(0, 0, 0, 0, 0, 0);
      for (int v = 1; v <= 5; v++) cyc(1, 0, 0, 1, N'(v), 0);
      cyc(1, 0, 0, 1, 8'd6, 0);
      cyc(1, 0, 0, 0, 8'd0, 1);
      cyc(1, 0, 0, 0, 8'd0, 1);
      chk($sformatf("pre%0d_level", p), int'(level_o), 3);
      chk($sformatf("pre%0d_ovf", p), int'(ovf_o), 1);
      if (p == 0) cyc(1, 1, 0, 1, 8'd77, 0);
      else        cyc(0, 0, 0, 1, 8'd77, 0);
      chk($sformatf("clr%0d_level", p), int'(level_o), 0);
      chk($sformatf("clr%0d_ovf", p), int'(ovf_o), 0);
      chk($sformatf("clr%0d_empty", p), int'(empty_o), 1);
      chk($sformatf("clr%0d_win0", p), int'(win[0]), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sync_fifo_window.md
# sync_fifo_window

Single-clock, parametrised FIFO with a parallel window view of all stored entries. It succeeds the shift-register asynchronous-enable FIFO. Generalised in width, depth and thresholds, it adds occupancy count, almost-full/almost-empty flags, a sticky error flag, a synchronous flush, and a selectable overwrite (ring) mode. It sits between a producer stream and consumers that need either ordered pops or a snapshot of the last M samples, such as filters and pattern matchers.

## Interface
Parameters:
- N, 32, data width in bits (≥1)
- M, 16, depth in entries (≥2, any integer)
- AF, M-2, almost-full threshold: afull_o=1 when level ≥ AF
- AE, 2, almost-empty threshold: aempty_o=1 when level ≤ AE
- LW, $clog2(M+1), width of level_o (derived, not overridden)

Ports:
- clk_i  in  1  single clock, all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-low
- clr_i  in  1  synchronous flush, active-high
- mode_i  in  1  0 = normal FIFO, 1 = overwrite/ring
- wr_i  in  1  write request
- wr_data_i  in  N  write data
- rd_i  in  1  read (pop) request
- rd_data_o  out  N  head entry, first-word-fall-through; 0 when empty
- full_o  out  1  level == M
- empty_o  out  1  level == 0
- afull_o  out  1  level ≥ AF
- aempty_o  out  1  level ≤ AE
- level_o  out  LW  current occupancy, 0..M
- ovf_o  out  1  sticky: write rejected while full (mode 0)
- udf_o  out  1  sticky: read while empty
- drop_o  out  1  1-cycle pulse: oldest entry discarded (mode 1)
- win_o  out  N×M  unpacked [0:M-1]; win_o[k] = k-th entry from head (0 = oldest)
- win_vld_o  out  M  win_vld_o[k] = (k < level)

## Operation
- Storage: M×N register array, head pointer, tail pointer and level counter. Pointers wrap from M-1 to 0 (modulo M, no power-of-2 requirement).
- Priority each edge: reset > clr_i > rd/wr.
- Reset (rst_i=0 at edge), then clr_i=1:
  - pointers=0, level=0, ovf/udf/drop=0.
  - Storage contents are don't-care but never visible: win_o[k]=0 where win_vld_o[k]=0.
- Accepted write: store at tail, tail+1, level+1.
- Accepted read: head+1, level-1.
- Cases by level (W = wr_i, R = rd_i):
  - level=0:
    - W accepted.
    - R ignored and sets udf_o, even when W=1.
  - 0<level<M: W and R each accepted independently. W&R together leaves level unchanged.
  - level=M, mode 0:
    - W&R: both accepted.
    - W alone: rejected, data lost, ovf_o set.
  - level=M, mode 1:
    - W alone: oldest entry dropped (head+1), new entry written, level stays M, drop_o=1.
    - W&R: behaves as normal W&R, drop_o=0.
- mode_i is sampled every edge. A change is legal at any level and takes effect for the operation at that same edge.
- Sticky flags clear only on reset or clr_i.
- Window entries are ordered oldest to newest. Invalid slots read 0.

## Timing
- Every output is a function of registered state only. No combinational path from wr_i, rd_i, clr_i or mode_i to any output.
- Write at edge t: visible on rd_data_o (if it was empty) and in win_o/level_o from just after edge t. Write-to-read latency is 1 cycle.
- Read at edge t: next entry appears on rd_data_o after edge t. Consumers sample rd_data_o in the same cycle they assert rd_i.
- Flags (full/empty/afull/aempty) are updated in the same edge as level_o.
- ovf_o and udf_o rise the edge after the offending request.
- drop_o is high for exactly the cycle following the dropping edge.
- Reset values: rd_data_o=0, full_o=0, empty_o=1, afull_o=(AF==0), aempty_o=1, level_o=0, ovf_o=0, udf_o=0, drop_o=0, win_o all 0, win_vld_o=0.
- Reset or clr_i mid-burst discards in-flight requests in that cycle.

## Test plan
- Reset with N=8, M=5, then write 1..5 on consecutive cycles:
  - level_o goes 1..5.
  - full_o=1 after the 5th edge.
  - win_o = {1,2,3,4,5}, win_vld_o = 5'b11111.
  - afull_o=1 from level 3 (AF=3).
- Mode 0, full, write 6 -> rejected, ovf_o=1, level_o stays 5, win_o unchanged. Then pop 5 times -> rd_data_o presents 1,2,3,4,5, empty_o=1, rd_data_o=0.
- Mode 1, full {1..5}, write 6 then 7 -> drop_o pulses twice, win_o = {3,4,5,6,7}, level_o=5, ovf_o=0.
- Pointer wrap: 3 writes and 3 reads repeated 4 times on M=5, with simultaneous W&R at level 2 -> data order preserved, level_o never exceeds 3, no flags set.
- Empty, wr_i=1 and rd_i=1 with data 0xA5 -> write accepted, udf_o=1, level_o=1, rd_data_o=0xA5.
- Level 3 with ovf_o=1, assert clr_i together with wr_i -> level_o=0, ovf_o=0, empty_o=1, write ignored. Repeat with rst_i=0 -> identical result.
